mesh_port_rr_arbiter: RTL and testbench

- Round-robin, packet-locking arbiter sharing one mesh router output port among N input requesters (default 8: local ports plus virtual-channel sources).
- Issues a registered one-hot grant and its binary-encoded index (the encoded index steers the output crossbar mux).
- Holds the grant for a whole packet and releases it on the transferred tail flit.
- Sits between the input-buffer request lines and the crossbar select logic.

---
 rtl/mesh_port_rr_arbiter.sv | 99 +++++++++
 tb/tb_mesh_port_rr_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mesh_port_rr_arbiter.sv
// Round-robin, packet-locking arbiter sharing one mesh router output port.
// The grant is registered and held from the head flit until the tail flit transfers.
module mesh_port_rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     tail_i,
    input  logic             ready_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             xfer_o,
    output logic             state_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    logic             pick_found;
    logic             release_w;

    // Handshake: a flit moves in a cycle only when the granted requester
    // presents it (req_i[gnt_idx_o]) and the downstream link is ready
    // (ready_i); neither side may make its own signal depend on the other's.
    assign xfer_o      = gnt_valid_o & req_i[idx_q] & ready_i;
    assign release_w   = xfer_o & tail_i[idx_q];

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = (state_q == LOCKED);
    assign state_o     = (state_q == LOCKED);

    // Search starts at rr_ptr and wraps naturally because N is a power of two.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 0; i < N; i++) begin
            cand = rr_ptr_q + IDX_W'(i);
            if (!pick_found && req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    idx_d           = pick_idx;
                    state_d         = LOCKED;
                end
            end
            LOCKED: begin
                // The index is kept after release; only the one-hot grant clears.
                if (release_w) begin
                    gnt_d    = '0;
                    rr_ptr_d = idx_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_mesh_port_rr_arbiter.sv
// Bench for mesh_port_rr_arbiter: directed packet scenarios plus random traffic,
// checked every cycle against a packet-level reference model.
module tb_mesh_port_rr_arbiter;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    // clock / reset
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_i = '0;
    logic [N-1:0]     tail_i = '0;
    logic             ready_i = 1'b0;
    logic [N-1:0]     gnt_o;
    logic [IDX_W-1:0] gnt_idx_o;
    logic             gnt_valid_o;
    logic             xfer_o;
    logic             state_o;

    always #5 clk = ~clk;

    mesh_port_rr_arbiter #(.N(N), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .tail_i      (tail_i),
        .ready_i     (ready_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .xfer_o      (xfer_o),
        .state_o     (state_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: owner of the port, last granted index, round-robin pointer
    logic             m_locked = 1'b0;
    int               m_idx = 0;
    int               m_rr = 0;
    logic [IDX_W-1:0] exp_q[$];
    logic             obs_prev_valid = 1'b0;

    // stimulus state: remaining flits of the packet at each requester's head
    int pkt_len[N];
    logic last_xfer;
    int   last_xfer_idx;

    task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] tail,
                         input logic rdy, input logic rst);
        logic [N-1:0] eg;
        logic         ex;
        int           best;
        int           bestd;
        int           d;
        @(negedge clk);
        req_i   = req;
        tail_i  = tail;
        ready_i = rdy;
        reset   = rst;
        #1;
        eg = '0;
        if (m_locked) eg[m_idx] = 1'b1;
        ex = m_locked && req[m_idx] && rdy;
        check("gnt", gnt_o, eg);
        check("gnt_valid", gnt_valid_o, m_locked);
        check("gnt_idx", gnt_idx_o, m_idx);
        check("xfer", xfer_o, ex);
        check("state", state_o, m_locked);
        check("inv_onehot0", $onehot0(gnt_o), 1);
        check("inv_valid_or", gnt_valid_o, |gnt_o);
        if (gnt_valid_o) check("inv_idx_match", gnt_o, 32'(1) << gnt_idx_o);
        if (gnt_valid_o && !obs_prev_valid) begin
            if (exp_q.size() > 0) check("grant_order", gnt_idx_o, exp_q.pop_front());
            else check("grant_unexpected", exp_q.size(), 1);
        end
        obs_prev_valid = gnt_valid_o;
        last_xfer      = ex && !rst;
        last_xfer_idx  = m_idx;
        @(posedge clk);
        if (rst) begin
            m_locked = 1'b0;
            m_idx    = 0;
            m_rr     = 0;
        end else if (m_locked) begin
            if (ex && tail[m_idx]) begin
                m_locked = 1'b0;
                m_rr     = (m_idx + 1) % N;
            end
        end else if (req != '0) begin
            best  = 0;
            bestd = N;
            for (int k = 0; k < N; k++) begin
                d = (k - m_rr + N) % N;
                if (req[k] && d < bestd) begin
                    bestd = d;
                    best  = k;
                end
            end
            m_locked = 1'b1;
            m_idx    = best;
            exp_q.push_back(IDX_W'(best));
        end
    endtask

    // drives requests from pkt_len; stall_en randomly withholds a head flit
    task automatic cycle_pkt(input logic rdy, input logic rst, input logic stall_en);
        logic [N-1:0] req;
        logic [N-1:0] tail;
        for (int k = 0; k < N; k++) begin
            req[k]  = (pkt_len[k] > 0) && !(stall_en && $urandom_range(0, 7) == 0);
            tail[k] = (pkt_len[k] == 1) || (stall_en && pkt_len[k] == 0 && $urandom_range(0, 1) == 1);
        end
        cycle(req, tail, rdy, rst);
        if (last_xfer && pkt_len[last_xfer_idx] > 0) pkt_len[last_xfer_idx]--;
    endtask

    task automatic clear_pkts();
        for (int k = 0; k < N; k++) pkt_len[k] = 0;
    endtask

    task automatic do_reset();
        clear_pkts();
        cycle_pkt(1'b0, 1'b1, 1'b0);
        cycle_pkt(1'b0, 1'b1, 1'b0);
    endtask

    logic ready_pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        clear_pkts();
        do_reset();

        // single-flit packet on requester 2
        pkt_len[2] = 1;
        repeat (4) cycle_pkt(1'b1, 1'b0, 1'b0);

        // all requesters, continuous single-flit packets
        do_reset();
        repeat (20) begin
            for (int k = 0; k < N; k++) if (pkt_len[k] == 0) pkt_len[k] = 1;
            cycle_pkt(1'b1, 1'b0, 1'b0);
        end

        // 4-flit packet on 5 while 1 waits
        do_reset();
        pkt_len[5] = 4;
        cycle_pkt(1'b1, 1'b0, 1'b0);
        pkt_len[1] = 1;
        repeat (8) cycle_pkt(1'b1, 1'b0, 1'b0);

        // locked on 3 with ready toggling
        do_reset();
        pkt_len[3] = 3;
        cycle_pkt(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle_pkt(ready_pat[i], 1'b0, 1'b0);
        repeat (2) cycle_pkt(1'b1, 1'b0, 1'b0);

        // wrap-around: packet from 6 leaves rr_ptr at 7
        do_reset();
        pkt_len[6] = 1;
        repeat (3) cycle_pkt(1'b1, 1'b0, 1'b0);
        pkt_len[7] = 1;
        pkt_len[0] = 1;
        repeat (6) cycle_pkt(1'b1, 1'b0, 1'b0);

        // reset mid-packet on 4, then 0 and 4 request
        do_reset();
        pkt_len[4] = 5;
        repeat (3) cycle_pkt(1'b1, 1'b0, 1'b0);
        clear_pkts();
        cycle_pkt(1'b1, 1'b1, 1'b0);
        pkt_len[0] = 1;
        pkt_len[4] = 1;
        repeat (6) cycle_pkt(1'b1, 1'b0, 1'b0);

        // random traffic with stalls, back-pressure and occasional reset
        do_reset();
        repeat (3000) begin
            for (int k = 0; k < N; k++)
                if (pkt_len[k] == 0 && $urandom_range(0, 3) == 0) pkt_len[k] = $urandom_range(1, 4);
            cycle_pkt($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, 1'b1);
        end
        clear_pkts();
        repeat (3) cycle_pkt(1'b1, 1'b0, 1'b0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
